div_issue_ctrl: RTL and testbench
=================================

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `resetn`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have the ports `req_valid` (input, 1) and `req_ready` (output, 1): the request handshake; a request is accepted on an edge where both are high.
REQ-004 SHALL have the ports `req_signed` (input, 1) and `req_rem` (input, 1): signed operands; return remainder (1) or quotient (0).
REQ-005 SHALL have the ports `req_x` and `req_y`, input, 32 bits each: dividend and divisor.
REQ-006 SHALL have the port `flush`, input, 1 bit: cancels any in-flight or held operation (branch taken / pipeline cancel).
REQ-007 SHALL have the ports `out_valid` (output, 1), `out_ready` (input, 1) and `out_result` (output, 32): the result handshake toward the next pipeline stage.
REQ-008 SHALL have the port `busy`, output, 1 bit: high in every state other than IDLE.

Function
REQ-009 SHALL implement a three-state FSM: IDLE -> BUSY on accept; BUSY -> DONE when the iteration count reaches 32; DONE -> IDLE on `out_valid & out_ready`.
REQ-010 SHALL drive `req_ready = ~flush & (IDLE | (DONE & out_ready))`, so a new request is accepted in the same cycle the previous result retires (back-to-back).
REQ-011 SHALL latch operands, sign and op at accept; later changes to `req_*` SHALL NOT affect the operation.
REQ-012 SHALL use a 6-bit iteration counter, cleared at accept and incremented once per BUSY cycle; `out_valid` SHALL rise exactly 33 edges after the accepting edge.
REQ-013 SHALL hold `out_valid` and a stable `out_result` in DONE until `out_ready` is sampled high.
REQ-014 SHALL compute the result with magnitude shift-subtract: quotient sign = sign(x) XOR sign(y), remainder sign = sign(x); unsigned mode ignores sign bits.
REQ-015 SHALL return, for signed -2^31 / -1, quotient 0x80000000 and remainder 0.
REQ-016 SHALL return, for divisor 0, quotient 0xFFFFFFFF and remainder x, in both signed and unsigned mode.
REQ-017 SHALL, when `flush` is high in BUSY or DONE, enter IDLE on the next edge and not assert `out_valid` for that operation.
REQ-018 SHALL give `flush` priority over both `req_valid` and `out_ready` when they occur in the same cycle.

Reset
REQ-019 SHALL, on `resetn` low at any time (including mid-BUSY), immediately force state IDLE, counter 0, `out_valid` 0, `busy` 0 and `out_result` 0.
REQ-020 SHALL present `req_ready` = 1 in the first cycle after reset deassertion, provided `flush` is low.

Configuration
REQ-021 SHALL support the macro DIV_ZERO_FAST_EN; when it is defined, a divisor of 0 SHALL go IDLE -> DONE directly, with `out_valid` 1 edge after accept and the REQ-016 values.
REQ-022 SHALL, when DIV_ZERO_FAST_EN is undefined, take the full 33-cycle latency for a divisor of 0, with the same result values.

Structure
REQ-023 SHALL place the FSM state encoding, the DIV_ITERS=32 constant and the operation-select constants in the shared package `div_pkg`.
REQ-024 SHALL instantiate exactly one sub-module, `div_core`: a one-bit-per-cycle restoring-division datapath (load, step, magnitude quotient/remainder outputs) sequenced by this controller.

Verification
REQ-025 SHALL pass: unsigned 100 / 7, quotient -> `out_result` = 14 at edge 33 after accept; remainder -> 2.
REQ-026 SHALL pass: signed -7 / 2 -> quotient 0xFFFFFFFD and remainder 0xFFFFFFFF; signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000.
REQ-027 SHALL pass: 5 / 0 -> quotient 0xFFFFFFFF and remainder 5, latency 1 with DIV_ZERO_FAST_EN defined and 33 without it.
REQ-028 SHALL pass: `flush` at iteration 10 -> `out_valid` never rises, IDLE next edge, and a new request is accepted the following cycle.
REQ-029 SHALL pass: `out_ready` held low 5 cycles in DONE -> `out_valid` and `out_result` stable; 20 / 3 issued in the retire cycle -> `req_ready` = 1 and the result is 6 at 33 edges.
REQ-030 SHALL pass: `resetn` pulsed low mid-BUSY -> `busy` and `out_valid` are 0 immediately, and no stale result appears afterward.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider issue controller.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = 6;

    localparam logic OP_QUO = 1'b0;
    localparam logic OP_REM = 1'b1;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// One-bit-per-cycle restoring divider on 32-bit magnitudes; sequencing is external.
module div_core (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quo_o,
    output logic [31:0] rem_o
);

    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] rem_shift;
    logic [32:0] diff;

    // Dividend bits shift out of the quotient register into the partial remainder.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        rem_shift = {rem_q, quo_q[31]};
        diff      = rem_shift - {1'b0, dvs_q};
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = 32'd0;
            dvs_d = divisor_i;
        end else if (step_i) begin
            if (!diff[32]) begin
                rem_d = diff[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = rem_shift[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo_q <= 32'd0;
            rem_q <= 32'd0;
            dvs_q <= 32'd0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/retire controller for the iterative divider with valid/ready on both sides.
// DIV_ZERO_FAST_EN: when defined, a zero divisor completes one edge after accept.
//
// state   | meaning
// IDLE    | no operation held, ready for a request
// BUSY    | core iterating, counter tracks completed steps
// DONE    | result presented on out_result until out_ready
module div_issue_ctrl
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_signed,
    input  logic        req_rem,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

`ifdef DIV_ZERO_FAST_EN
    localparam logic ZERO_FAST = 1'b1;
`else
    localparam logic ZERO_FAST = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             yzero_q, yzero_d;
    logic [31:0]      result_q, result_d;

    logic        accept;
    logic        fast_zero;
    logic        core_step;
    logic [31:0] x_mag, y_mag;
    logic [31:0] quo_mag, rem_mag;
    logic [31:0] fin_quo, fin_rem;

    assign req_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept    = req_valid & req_ready;
    assign fast_zero = ZERO_FAST & (req_y == 32'd0);

    assign x_mag = cond_neg(req_x, req_signed & req_x[31]);
    assign y_mag = cond_neg(req_y, req_signed & req_y[31]);

    // A zero divisor leaves the core quotient all-ones, but sign fix-up would corrupt it.
    assign fin_quo = yzero_q ? 32'hFFFF_FFFF : cond_neg(quo_mag, negq_q);
    assign fin_rem = cond_neg(rem_mag, negr_q);

    div_core u_core (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (accept),
        .step_i     (core_step),
        .dividend_i (x_mag),
        .divisor_i  (y_mag),
        .quo_o      (quo_mag),
        .rem_o      (rem_mag)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        yzero_d   = yzero_q;
        result_d  = result_q;
        core_step = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_BUSY: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d  = ST_DONE;
                        result_d = (op_q == OP_REM) ? fin_rem : fin_quo;
                    end else begin
                        cnt_d     = cnt_q + 6'd1;
                        core_step = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: ;
            endcase
            // Accept is only possible from IDLE or a retiring DONE, so this overrides cleanly.
            if (accept) begin
                cnt_d   = '0;
                op_d    = req_rem;
                negq_d  = req_signed & (req_x[31] ^ req_y[31]);
                negr_d  = req_signed & req_x[31];
                yzero_d = (req_y == 32'd0);
                if (fast_zero) begin
                    state_d  = ST_DONE;
                    result_d = (req_rem == OP_REM) ? req_x : 32'hFFFF_FFFF;
                end else begin
                    state_d = ST_BUSY;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_QUO;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            yzero_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            yzero_q  <= yzero_d;
            result_q <= result_d;
        end
    end

    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_result = result_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl against an arithmetic reference model.
module tb_div_issue_ctrl;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic        req_rem;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    div_issue_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_signed (req_signed),
        .req_rem    (req_rem),
        .req_x      (req_x),
        .req_y      (req_y),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s, input logic r);
        logic [31:0] v;
        if (y == 32'd0) return r ? x : 32'hFFFF_FFFF;
        if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
            if (r) v = $signed(x) % $signed(y);
            else   v = $signed(x) / $signed(y);
            return v;
        end
        return r ? (x % y) : (x / y);
    endfunction

    function automatic int ref_lat(input logic [31:0] y);
        return (y == 32'd0) ? ZLAT : 33;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge with req_* scrambled.
    task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                            input logic r, output bit ok);
        ok         = 1'b0;
        req_x      = x;
        req_y      = y;
        req_signed = s;
        req_rem    = r;
        req_valid  = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        out_ready  = 1'b0;
        req_x      = $urandom;
        req_y      = $urandom;
        req_signed = 1'($urandom);
        req_rem    = 1'($urandom);
    endtask

    // Counts edges after the accept edge until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat, output logic [31:0] res);
        lat = 0;
        res = 32'd0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
        res = out_result;
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        n_cmp += 3;
        if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (out_result !== 32'd0) begin n_bad++; $display("FAIL reset_out_result: got %h want 0", out_result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    endtask

    logic [31:0] dx [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000,
                             32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] dy [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        ds [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        dr [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic test_directed();
        bit          ok;
        int          lat;
        logic [31:0] res, exp;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            start_op(dx[i], dy[i], ds[i], dr[i], ok);
            wait_valid(lat, res);
            exp = ref_div(dx[i], dy[i], ds[i], dr[i]);
            n_cmp += 3;
            if (!ok) begin n_bad++; $display("FAIL dir_accept[%0d]: req_ready never high", i); end
            if (lat != ref_lat(dy[i])) begin
                n_bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, ref_lat(dy[i]));
            end
            if (res !== exp) begin
                n_bad++; $display("FAIL dir_result[%0d]: got %h want %h", i, res, exp);
            end
            retire();
        end
    endtask

    task automatic test_random();
        bit          ok;
        int          lat;
        logic [31:0] x, y, res, exp;
        logic        s, r;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            s = 1'($urandom);
            r = 1'($urandom);
            @(negedge clk);
            start_op(x, y, s, r, ok);
            n_cmp++;
            if (busy !== 1'b1) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want 1", i, busy); end
            wait_valid(lat, res);
            exp = ref_div(x, y, s, r);
            n_cmp += 3;
            if (!ok) begin n_bad++; $display("FAIL rnd_accept[%0d]: req_ready never high", i); end
            if (lat != ref_lat(y)) begin
                n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, ref_lat(y));
            end
            if (res !== exp) begin
                n_bad++; $display("FAIL rnd_result[%0d] x=%h y=%h s=%b r=%b: got %h want %h", i, x, y, s, r, res, exp);
            end
            retire();
            #1;
            n_cmp++;
            if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_idle[%0d]: got busy %b want 0", i, busy); end
        end
    endtask

    task automatic test_flush();
        bit          ok;
        int          lat;
        logic [31:0] res;
        @(negedge clk);
        start_op(32'd100, 32'd7, 1'b0, 1'b0, ok);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL flush_busy_idle: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_busy_valid: got %b want 0", out_valid); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_next_ready: got %b want 1", req_ready); end
        start_op(32'd20, 32'd3, 1'b0, 1'b0, ok);
        wait_valid(lat, res);
        n_cmp += 2;
        if (lat != 33)     begin n_bad++; $display("FAIL flush_next_latency: got %0d want 33", lat); end
        if (res !== 32'd6) begin n_bad++; $display("FAIL flush_next_result: got %h want 6", res); end
        // Flush in DONE beats both a retire and a new request in the same cycle.
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        req_valid = 1'b1;
        req_y     = 32'd9;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_done_ready: got %b want 0", req_ready); end
        @(posedge clk);
        #1;
        n_cmp += 2;
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL flush_done_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done_valid: got %b want 0", out_valid); end
        @(negedge clk);
        flush     = 1'b0;
        out_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          lat;
        logic [31:0] res, exp;
        exp = ref_div(32'd1000, 32'd10, 1'b0, 1'b0);
        @(negedge clk);
        start_op(32'd1000, 32'd10, 1'b0, 1'b0, ok);
        wait_valid(lat, res);
        n_cmp++;
        if (res !== exp) begin n_bad++; $display("FAIL b2b_first: got %h want %h", res, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp += 2;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_hold_valid[%0d]: got %b want 1", i, out_valid); end
            if (out_result !== exp) begin n_bad++; $display("FAIL b2b_hold_result[%0d]: got %h want %h", i, out_result, exp); end
        end
        out_ready = 1'b1;
        req_valid = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_retire_ready: got %b want 1", req_ready); end
        start_op(32'd20, 32'd3, 1'b0, 1'b0, ok);
        wait_valid(lat, res);
        n_cmp += 2;
        if (lat != 33)     begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        if (res !== 32'd6) begin n_bad++; $display("FAIL b2b_result: got %h want 6", res); end
        retire();
    endtask

    task automatic test_reset_mid_busy();
        bit          ok;
        bit          seen;
        int          lat;
        logic [31:0] res;
        @(negedge clk);
        start_op(32'd100, 32'd7, 1'b0, 1'b1, ok);
        repeat (15) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp += 3;
        if (busy !== 1'b0)        begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        if (out_result !== 32'd0) begin n_bad++; $display("FAIL rst_mid_result: got %h want 0", out_result); end
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL rst_mid_stale: got activity after reset want none"); end
        @(negedge clk);
        start_op(32'd100, 32'd7, 1'b0, 1'b1, ok);
        wait_valid(lat, res);
        n_cmp += 2;
        if (lat != 33)     begin n_bad++; $display("FAIL rst_after_latency: got %0d want 33", lat); end
        if (res !== 32'd2) begin n_bad++; $display("FAIL rst_after_result: got %h want 2", res); end
        retire();
    endtask

    initial begin
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_rem    = 1'b0;
        req_x      = 32'd0;
        req_y      = 32'd0;
        flush      = 1'b0;
        out_ready  = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_back_to_back();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
